// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic-array sequencer:
//   - default array dimension and maximum reduction length
//   - derived index / length / counter widths
//   - sequencer state type
// -----------------------------------------------------------------------------
package systolic_pkg;

    // Default array dimension (N x N processing elements).
    localparam int N_DEF    = 4;
    // Default maximum reduction length K.
    localparam int KMAX_DEF = 256;

    // Operand index width: addresses k = 0 .. KMAX-1.
    localparam int KW_DEF   = $clog2(KMAX_DEF);
    // Length width: holds K = 0 .. KMAX.
    localparam int LW_DEF   = $clog2(KMAX_DEF + 1);

    // Feed counter width: t never exceeds K+2N-3, so KMAX+2N values are enough.
    function automatic int cnt_width(input int n, input int kmax);
        return $clog2(kmax + 2 * n);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FEED  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage : systolic_pkg

// File: rtl/systolic_skew.sv
// -----------------------------------------------------------------------------
// systolic_skew
// Skewed operand-index decode for one edge of the array (all N rows of A, or
// all N columns of B). Lane i is active while i <= t < i+K and then reads
// operand element k = t-i, which staggers the wavefront by one cycle per lane.
//
// Ports
//   feed_i  in   1       sequencer is in the FEED state
//   t_i     in   TW      feed cycle counter
//   k_i     in   LW      reduction length K of the current pass
//   idx_o   out  N*KW    per-lane k index, lane i at [i*KW +: KW]; 0 when idle
//   vld_o   out  N       per-lane valid
// -----------------------------------------------------------------------------
module systolic_skew
    import systolic_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int KMAX = KMAX_DEF,
    parameter int KW   = $clog2(KMAX),
    parameter int LW   = $clog2(KMAX + 1),
    parameter int TW   = cnt_width(N, KMAX)
) (
    input  logic            feed_i,
    input  logic [TW-1:0]   t_i,
    input  logic [LW-1:0]   k_i,
    output logic [N*KW-1:0] idx_o,
    output logic [N-1:0]    vld_o
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [TW-1:0] LANE = TW'(i);

        logic [TW-1:0] off;
        logic          in_win;

        // off wraps when t < i, so the t >= i term must gate the window test.
        assign off    = t_i - LANE;
        assign in_win = feed_i && (t_i >= LANE) && (off < TW'(k_i));

        assign vld_o[i]            = in_win;
        // off < K <= KMAX inside the window, so the low KW bits are exact.
        assign idx_o[i*KW +: KW]   = in_win ? off[KW-1:0] : '0;
    end

endmodule : systolic_skew

// File: rtl/systolic_seq.sv
// -----------------------------------------------------------------------------
// systolic_seq
// Sequencer for an N x N output-stationary systolic array. One pass clears the
// array, streams K skewed operand indices into the west (A rows) and north
// (B columns) edges, then flags the accumulators as holding a full result.
// All outputs are decoded from registered state only.
//
// Ports
//   clk          in   1       clock, rising edge
//   rst          in   1       synchronous active-high reset
//   start_i      in   1       start a pass (sampled only in IDLE)
//   k_len_i      in   LW      reduction length, saturated to KMAX on capture
//   busy_o       out  1       not IDLE
//   done_o       out  1       one-cycle completion pulse (DONE state)
//   res_vld_o    out  1       accumulators hold a complete result
//   array_clr_o  out  1       clear pulse for every PE register
//   a_idx_o      out  N*KW    per-row A index, lane i at [i*KW +: KW]
//   a_vld_o      out  N       per-row A valid
//   b_idx_o      out  N*KW    per-column B index, lane j at [j*KW +: KW]
//   b_vld_o      out  N       per-column B valid
// -----------------------------------------------------------------------------
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int KMAX = KMAX_DEF,
    localparam int KW  = $clog2(KMAX),
    localparam int LW  = $clog2(KMAX + 1),
    localparam int TW  = cnt_width(N, KMAX)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [LW-1:0]   k_len_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            res_vld_o,
    output logic            array_clr_o,
    output logic [N*KW-1:0] a_idx_o,
    output logic [N-1:0]    a_vld_o,
    output logic [N*KW-1:0] b_idx_o,
    output logic [N-1:0]    b_vld_o
);

    seq_state_t    state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [LW-1:0] k_q, k_d;
    logic          res_vld_q, res_vld_d;

    logic [LW-1:0] k_sat;
    logic [TW-1:0] t_last;
    logic          feed;

    assign k_sat  = (k_len_i > LW'(KMAX)) ? LW'(KMAX) : k_len_i;

    // Last feed cycle is K+2N-3: the final product reaches PE(N-1,N-1) after
    // K-1 operand steps plus 2(N-1) cycles of skew. Only used when K > 0.
    assign t_last = TW'(k_q) + TW'(2 * N - 2) - TW'(1);

    // -------------------------------------------------------------------------
    // Next-state / counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold the value.
        state_d   = state_q;
        t_d       = t_q;
        k_d       = k_q;
        res_vld_d = res_vld_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    k_d       = k_sat;
                    t_d       = '0;
                    res_vld_d = 1'b0;
                    state_d   = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                t_d = '0;
                if (k_q == '0) begin
                    res_vld_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_FEED;
                end
            end

            ST_FEED: begin
                if (t_q == t_last) begin
                    t_d       = '0;
                    res_vld_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end

            ST_DONE: begin
                // start_i is deliberately ignored here; it is honoured in the
                // IDLE cycle that follows.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of its inputs, independent of statement order.
        if (rst) begin
            state_q   <= ST_IDLE;
            t_q       <= '0;
            k_q       <= '0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            k_q       <= k_d;
            res_vld_q <= res_vld_d;
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs
    // -------------------------------------------------------------------------
    assign feed        = (state_q == ST_FEED);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign array_clr_o = (state_q == ST_CLEAR);
    assign res_vld_o   = res_vld_q;

    // A rows and B columns share the same skew rule and timing.
    systolic_skew #(
        .N    (N),
        .KMAX (KMAX),
        .KW   (KW),
        .LW   (LW),
        .TW   (TW)
    ) u_skew_a (
        .feed_i (feed),
        .t_i    (t_q),
        .k_i    (k_q),
        .idx_o  (a_idx_o),
        .vld_o  (a_vld_o)
    );

    systolic_skew #(
        .N    (N),
        .KMAX (KMAX),
        .KW   (KW),
        .LW   (LW),
        .TW   (TW)
    ) u_skew_b (
        .feed_i (feed),
        .t_i    (t_q),
        .k_i    (k_q),
        .idx_o  (b_idx_o),
        .vld_o  (b_vld_o)
    );

endmodule : systolic_seq

// File: tb/tb_systolic_seq.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq
// Self-checking bench for systolic_seq (N=4, KMAX=256). Expected sequencer
// outputs come from a cycle-index model of a pass; a behavioural PE array
// closes the loop and is compared against plain matrix products.
// -----------------------------------------------------------------------------
module tb_systolic_seq;

    localparam int N    = 4;
    localparam int KMAX = 256;
    localparam int KW   = $clog2(KMAX);
    localparam int LW   = $clog2(KMAX + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [LW-1:0]   k_len_i;
    logic            busy_o;
    logic            done_o;
    logic            res_vld_o;
    logic            array_clr_o;
    logic [N*KW-1:0] a_idx_o;
    logic [N-1:0]    a_vld_o;
    logic [N*KW-1:0] b_idx_o;
    logic [N-1:0]    b_vld_o;

    systolic_seq #(
        .N    (N),
        .KMAX (KMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .k_len_i     (k_len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .res_vld_o   (res_vld_o),
        .array_clr_o (array_clr_o),
        .a_idx_o     (a_idx_o),
        .a_vld_o     (a_vld_o),
        .b_idx_o     (b_idx_o),
        .b_vld_o     (b_vld_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            res_vld;
        logic            clr;
        logic [N-1:0]    a_vld;
        logic [N-1:0]    b_vld;
        logic [N*KW-1:0] a_idx;
        logic [N*KW-1:0] b_idx;
    } obs_t;

    // -------------------------------------------------------------------------
    // Reference model: expected outputs in cycle c (1-based) after the edge
    // that accepted start, for saturated length k.
    // -------------------------------------------------------------------------
    function automatic int pass_len(input int k);
        return (k == 0) ? 2 : k + 2 * N;
    endfunction

    function automatic obs_t model_pass(input int c, input int k);
        obs_t o;
        int   t;
        o      = '0;
        o.busy = 1'b1;
        if (c == 1) begin
            o.clr = 1'b1;
        end else if (c == pass_len(k)) begin
            o.done    = 1'b1;
            o.res_vld = 1'b1;
        end else begin
            t = c - 2;
            for (int i = 0; i < N; i++) begin
                if (t >= i && t < i + k) begin
                    o.a_vld[i]          = 1'b1;
                    o.b_vld[i]          = 1'b1;
                    o.a_idx[i*KW +: KW] = KW'(t - i);
                    o.b_idx[i*KW +: KW] = KW'(t - i);
                end
            end
        end
        return o;
    endfunction

    function automatic obs_t idle_obs(input logic res);
        obs_t o;
        o         = '0;
        o.res_vld = res;
        return o;
    endfunction

    function automatic obs_t sample();
        return {busy_o, done_o, res_vld_o, array_clr_o,
                a_vld_o, b_vld_o, a_idx_o, b_idx_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Behavioural PE array driven by the sequencer
    // -------------------------------------------------------------------------
    logic [7:0]  mat_a [N][KMAX];
    logic [7:0]  mat_b [KMAX][N];
    logic [7:0]  pe_a  [N][N];
    logic [7:0]  pe_b  [N][N];
    logic [31:0] acc   [N][N];

    function automatic logic [7:0] a_in(input int i, input int j);
        if (j == 0)
            return a_vld_o[i] ? mat_a[i][a_idx_o[i*KW +: KW]] : 8'd0;
        return pe_a[i][j-1];
    endfunction

    function automatic logic [7:0] b_in(input int i, input int j);
        if (i == 0)
            return b_vld_o[j] ? mat_b[b_idx_o[j*KW +: KW]][j] : 8'd0;
        return pe_b[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (array_clr_o) begin
                    pe_a[i][j] <= 8'd0;
                    pe_b[i][j] <= 8'd0;
                    acc[i][j]  <= 32'd0;
                end else begin
                    pe_a[i][j] <= a_in(i, j);
                    pe_b[i][j] <= b_in(i, j);
                    acc[i][j]  <= acc[i][j] + 32'(a_in(i, j)) * 32'(b_in(i, j));
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        obs_t act;
        rst     = 1'b1;
        start_i = 1'b1;
        k_len_i = LW'(5);
        tick();
        tick();
        act = sample();
        n_tests++;
        if (act !== idle_obs(1'b0)) begin
            n_fail++;
            $display("FAIL reset_hold got=%h exp=%h", act, idle_obs(1'b0));
        end
        rst     = 1'b0;
        start_i = 1'b0;
        tick();
        act = sample();
        n_tests++;
        if (act !== idle_obs(1'b0)) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", act, idle_obs(1'b0));
        end
    endtask

    // One full pass checked cycle by cycle. With noise, start_i/k_len_i toggle
    // randomly while busy and start_i is forced high in the DONE cycle.
    task automatic test_pass(input int k_req, input bit noise, input string name);
        obs_t act, exp;
        int   k, last;
        k    = (k_req > KMAX) ? KMAX : k_req;
        last = pass_len(k);
        start_i = 1'b1;
        k_len_i = LW'(k_req);
        tick();
        for (int c = 1; c <= last; c++) begin
            act = sample();
            exp = model_pass(c, k);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s k=%0d c=%0d got=%h exp=%h", name, k, c, act, exp);
            end
            if (noise) begin
                start_i = 1'($urandom);
                k_len_i = LW'($urandom);
                if (c == last) start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            tick();
        end
        act = sample();
        n_tests++;
        if (act !== idle_obs(1'b1)) begin
            n_fail++;
            $display("FAIL %s_idle1 got=%h exp=%h", name, act, idle_obs(1'b1));
        end
        start_i = 1'b0;
        tick();
        act = sample();
        n_tests++;
        if (act !== idle_obs(1'b1)) begin
            n_fail++;
            $display("FAIL %s_idle2 got=%h exp=%h", name, act, idle_obs(1'b1));
        end
    endtask

    task automatic test_basic_k8();
        int clr_c  = -1;
        int done_c = -1;
        int a3     = 0;
        start_i = 1'b1;
        k_len_i = LW'(8);
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (array_clr_o && clr_c < 0) clr_c = c;
            if (a_vld_o[3]) begin
                n_tests++;
                if (a_idx_o[3*KW +: KW] !== KW'(a3)) begin
                    n_fail++;
                    $display("FAIL k8_a3_idx c=%0d got=%0d exp=%0d", c, a_idx_o[3*KW +: KW], a3);
                end
                n_tests++;
                if (!(c - 2 >= 3 && c - 2 <= 10)) begin
                    n_fail++;
                    $display("FAIL k8_a3_window t=%0d got=vld exp=3..10", c - 2);
                end
                a3++;
            end
            if (done_o) begin
                done_c = c;
                break;
            end
            tick();
        end
        n_tests++;
        if (clr_c != 1) begin
            n_fail++;
            $display("FAIL k8_clr_cycle got=%0d exp=1", clr_c);
        end
        n_tests++;
        if (done_c != 16) begin
            n_fail++;
            $display("FAIL k8_done_cycle got=%0d exp=16", done_c);
        end
        n_tests++;
        if (a3 != 8) begin
            n_fail++;
            $display("FAIL k8_a3_count got=%0d exp=8", a3);
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        obs_t act, exp;
        int   p;
        start_i = 1'b1;
        k_len_i = LW'(1);
        tick();
        for (int c = 1; c <= 30; c++) begin
            p   = (c - 1) % 10 + 1;
            exp = (p <= 9) ? model_pass(p, 1) : idle_obs(1'b1);
            act = sample();
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL b2b c=%0d got=%h exp=%h", c, act, exp);
            end
            if (c == 30) start_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_mid_reset();
        obs_t act;
        start_i = 1'b1;
        k_len_i = LW'(8);
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        act = sample();
        n_tests++;
        if (act !== model_pass(7, 8)) begin
            n_fail++;
            $display("FAIL midrst_t5 got=%h exp=%h", act, model_pass(7, 8));
        end
        rst = 1'b1;
        tick();
        act = sample();
        n_tests++;
        if (act !== idle_obs(1'b0)) begin
            n_fail++;
            $display("FAIL midrst_abort got=%h exp=%h", act, idle_obs(1'b0));
        end
        rst = 1'b0;
        tick();
        act = sample();
        n_tests++;
        if (act !== idle_obs(1'b0)) begin
            n_fail++;
            $display("FAIL midrst_after got=%h exp=%h", act, idle_obs(1'b0));
        end
        test_pass(8, 1'b0, "after_rst");
    endtask

    task automatic test_random_passes();
        for (int r = 0; r < 6; r++) begin
            test_pass(int'($urandom_range(0, 20)), 1'b1, "rand");
        end
    endtask

    task automatic test_closed_loop();
        int unsigned expv;
        bit          seen;
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < 8; k++) begin
                    mat_a[i][k] = 8'($urandom);
                    mat_b[k][i] = 8'($urandom);
                end
            end
            start_i = 1'b1;
            k_len_i = LW'(8);
            tick();
            start_i = 1'b0;
            seen    = 1'b0;
            for (int c = 1; c <= 64; c++) begin
                if (done_o) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL loop_done_timeout got=no_done exp=done");
            end
            n_tests++;
            if (res_vld_o !== 1'b1) begin
                n_fail++;
                $display("FAIL loop_res_vld got=%b exp=1", res_vld_o);
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    expv = 0;
                    for (int k = 0; k < 8; k++)
                        expv += int'(mat_a[i][k]) * int'(mat_b[k][j]);
                    n_tests++;
                    if (acc[i][j] !== expv) begin
                        n_fail++;
                        $display("FAIL loop_pe[%0d][%0d] got=%0d exp=%0d", i, j, acc[i][j], expv);
                    end
                end
            end
            tick();
            tick();
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        k_len_i = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < KMAX; k++) begin
                mat_a[i][k] = 8'd0;
                mat_b[k][i] = 8'd0;
            end
        end
        #1;
        test_reset();
        test_basic_k8();
        test_pass(8, 1'b0, "k8_full");
        test_pass(0, 1'b0, "k0");
        test_pass(300, 1'b1, "sat");
        test_back_to_back();
        test_mid_reset();
        test_random_passes();
        test_closed_loop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_systolic_seq
